// File: rtl/pix_write_ctrl.sv
// Frame-write sequencer: re-times upstream pixel pairs onto the BMP writer's hsync/DATA_WRITE_* beat.
// Optional stall watchdog is built when PIXCTRL_TIMEOUT_EN is defined.
module pix_write_ctrl #(
  parameter int WIDTH   = 340,
  parameter int HEIGHT  = 230,
  parameter int HBLANK  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  IN_R0,
  input  logic [7:0]  IN_G0,
  input  logic [7:0]  IN_B0,
  input  logic [7:0]  IN_R1,
  input  logic [7:0]  IN_G1,
  input  logic [7:0]  IN_B1,
  output logic        hsync,
  output logic [7:0]  DATA_WRITE_R0,
  output logic [7:0]  DATA_WRITE_G0,
  output logic [7:0]  DATA_WRITE_B0,
  output logic [7:0]  DATA_WRITE_R1,
  output logic [7:0]  DATA_WRITE_G1,
  output logic [7:0]  DATA_WRITE_B1,
  output logic [15:0] row,
  output logic [15:0] col,
  output logic        busy,
  output logic        frame_done,
  output logic        err
);

  localparam logic [15:0] LAST_COL = 16'(WIDTH / 2 - 1);
  localparam logic [15:0] LAST_ROW = 16'(HEIGHT - 1);
  localparam int          BLANK_W  = (HBLANK > 1) ? $clog2(HBLANK + 1) : 1;
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(HBLANK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_BLANK,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] r0;
    logic [7:0] g0;
    logic [7:0] b0;
    logic [7:0] r1;
    logic [7:0] g1;
    logic [7:0] b1;
  } pix_pair_t;

  state_t             state;
  pix_pair_t          pair_q;
  pix_pair_t          pair_in;
  logic [BLANK_W-1:0] blank_cnt;
  logic               accept;
  logic               stall_trip;

  assign pair_in = {IN_R0, IN_G0, IN_B0, IN_R1, IN_G1, IN_B1};
  assign accept  = in_valid && in_ready;

  assign DATA_WRITE_R0 = pair_q.r0;
  assign DATA_WRITE_G0 = pair_q.g0;
  assign DATA_WRITE_B0 = pair_q.b0;
  assign DATA_WRITE_R1 = pair_q.r1;
  assign DATA_WRITE_G1 = pair_q.g1;
  assign DATA_WRITE_B1 = pair_q.b1;

`ifdef PIXCTRL_TIMEOUT_EN
  localparam int                 STALL_W    = $clog2(TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

  logic [STALL_W-1:0] stall_cnt;

  // Trips on the TIMEOUT-th consecutive ACTIVE cycle without a beat; BLANK never counts.
  assign stall_trip = (state == S_ACTIVE) && !accept && (stall_cnt == STALL_LAST);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if (state != S_ACTIVE || accept) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (stall_trip) begin
        err <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  // TIMEOUT has no function without the watchdog.
  assign unused_timeout = (TIMEOUT != 0);
  assign stall_trip     = 1'b0;
  assign err            = 1'b0;
`endif

  // NOTE: all state here is updated with <=; the pulse defaults at the top of the
  // else branch make hsync/frame_done one-cycle strobes without any latch.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      hsync      <= 1'b0;
      frame_done <= 1'b0;
      row        <= '0;
      col        <= '0;
      pair_q     <= '0;
      blank_cnt  <= '0;
    end else begin
      hsync      <= 1'b0;
      frame_done <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_ACTIVE;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            row      <= '0;
            col      <= '0;
          end
        end

        S_ACTIVE: begin
          if (stall_trip) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end else if (accept) begin
            hsync  <= 1'b1;
            pair_q <= pair_in;
            if (col != LAST_COL) begin
              col <= col + 16'd1;
            end else if (row == LAST_ROW) begin
              state    <= S_DONE;
              in_ready <= 1'b0;
            end else begin
              col <= '0;
              row <= row + 16'd1;
              if (HBLANK > 0) begin
                state     <= S_BLANK;
                in_ready  <= 1'b0;
                blank_cnt <= BLANK_LOAD;
              end
            end
          end
        end

        S_BLANK: begin
          // Entry cycle counts as the first blank cycle, so exit when the count reaches 1.
          if (blank_cnt <= BLANK_W'(1)) begin
            state    <= S_ACTIVE;
            in_ready <= 1'b1;
          end else begin
            blank_cnt <= blank_cnt - 1'b1;
          end
        end

        S_DONE: begin
          // First DONE cycle raises frame_done; the second returns to IDLE, so start
          // seen while frame_done is high is dropped.
          if (!frame_done) begin
            frame_done <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pix_write_ctrl.sv
// Scoreboard bench for pix_write_ctrl: two instances (HBLANK=2 and HBLANK=0) share stimulus,
// a select picks which one the scenario observes.
module tb_pix_write_ctrl;

  localparam int W     = 8;
  localparam int H     = 3;
  localparam int PAIRS = W * H / 2;
  localparam int TMO   = 16;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic       start;
  logic       in_valid;
  logic [7:0] in_r0, in_g0, in_b0, in_r1, in_g1, in_b1;
  logic       sel;

  wire        a_ready, a_hsync, a_busy, a_done, a_err;
  wire [15:0] a_row, a_col;
  wire [47:0] a_data;
  wire        b_ready, b_hsync, b_busy, b_done, b_err;
  wire [15:0] b_row, b_col;
  wire [47:0] b_data;

  wire [84:0] a_all = {a_ready, a_hsync, a_busy, a_done, a_err, a_row, a_col, a_data};
  wire [84:0] b_all = {b_ready, b_hsync, b_busy, b_done, b_err, b_row, b_col, b_data};

  wire        mon_ready = sel ? b_ready : a_ready;
  wire        mon_hsync = sel ? b_hsync : a_hsync;
  wire        mon_busy  = sel ? b_busy  : a_busy;
  wire        mon_done  = sel ? b_done  : a_done;
  wire [15:0] mon_row   = sel ? b_row   : a_row;
  wire [15:0] mon_col   = sel ? b_col   : a_col;
  wire [47:0] mon_data  = sel ? b_data  : a_data;

  pix_write_ctrl #(.WIDTH(W), .HEIGHT(H), .HBLANK(2), .TIMEOUT(TMO)) dut_a (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .in_valid(in_valid), .in_ready(a_ready),
    .IN_R0(in_r0), .IN_G0(in_g0), .IN_B0(in_b0), .IN_R1(in_r1), .IN_G1(in_g1), .IN_B1(in_b1),
    .hsync(a_hsync),
    .DATA_WRITE_R0(a_data[47:40]), .DATA_WRITE_G0(a_data[39:32]), .DATA_WRITE_B0(a_data[31:24]),
    .DATA_WRITE_R1(a_data[23:16]), .DATA_WRITE_G1(a_data[15:8]),  .DATA_WRITE_B1(a_data[7:0]),
    .row(a_row), .col(a_col), .busy(a_busy), .frame_done(a_done), .err(a_err)
  );

  pix_write_ctrl #(.WIDTH(W), .HEIGHT(H), .HBLANK(0), .TIMEOUT(TMO)) dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .in_valid(in_valid), .in_ready(b_ready),
    .IN_R0(in_r0), .IN_G0(in_g0), .IN_B0(in_b0), .IN_R1(in_r1), .IN_G1(in_g1), .IN_B1(in_b1),
    .hsync(b_hsync),
    .DATA_WRITE_R0(b_data[47:40]), .DATA_WRITE_G0(b_data[39:32]), .DATA_WRITE_B0(b_data[31:24]),
    .DATA_WRITE_R1(b_data[23:16]), .DATA_WRITE_G1(b_data[15:8]),  .DATA_WRITE_B1(b_data[7:0]),
    .row(b_row), .col(b_col), .busy(b_busy), .frame_done(b_done), .err(b_err)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [47:0] data;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   gap_after[$];
  int   gap_len[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   k, n_hs, n_done, done_cyc, last_hs_cyc;

  function automatic logic [47:0] pair_of(input int idx);
    logic [7:0] b;
    b = 8'(idx);
    return {b, b + 8'd1, b + 8'd2, b + 8'd3, b + 8'd4, b + 8'd5};
  endfunction

  task automatic step();
    @(posedge HCLK);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    HRESET = 1'b1;
    start  = 1'b0;
    for (int i = 0; i < n; i++) step();
    HRESET = 1'b0;
  endtask

  // Drives one frame on the selected instance and scoreboards every hsync beat.
  // valid_mode 0: in_valid held high; 1: in_valid on every other cycle.
  task automatic run_frame(input int valid_mode, input int abort_at, input bit mid_start,
                           input bit start_on_done);
    int after_done;
    int gap_run;
    bit seen_ready;
    bit in_gap;
    exp_t e;
    sb_q.delete();
    gap_after.delete();
    gap_len.delete();
    k = 0; n_hs = 0; n_done = 0; done_cyc = -1; last_hs_cyc = -1;
    after_done = 0; gap_run = 0; seen_ready = 0; in_gap = 0;
    start = 1'b1;
    for (int t = 0; t < 400; t++) begin
      in_valid = (valid_mode == 0) ? 1'b1 : (t % 2 == 0);
      {in_r0, in_g0, in_b0, in_r1, in_g1, in_b1} = pair_of(k);
      if (mid_start && t == 9) start = 1'b1;
      if (start_on_done && mon_done) start = 1'b1;
      if (in_valid && mon_ready) begin
        sb_q.push_back('{pair_of(k), cyc + 1});
        k++;
      end
      step();
      start = 1'b0;

      if (mon_hsync) begin
        n_hs++;
        last_hs_cyc = cyc;
        n_checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL sb_unexpected_hsync: hsync at cycle %0d, required no beat", cyc);
        end else begin
          e = sb_q.pop_front();
          if (mon_data !== e.data || cyc != e.due)
            $display("FAIL sb_pair: got %h at cycle %0d, required %h at cycle %0d",
                     mon_data, cyc, e.data, e.due);
          else
            n_pass++;
        end
      end
      if (mon_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (mon_ready) begin
        if (in_gap) begin
          gap_len.push_back(gap_run);
          in_gap = 0;
        end
        seen_ready = 1;
      end else if (seen_ready && k < PAIRS) begin
        if (!in_gap) begin
          in_gap  = 1;
          gap_run = 0;
          gap_after.push_back(k);
        end
        gap_run++;
      end

      if (abort_at > 0 && n_hs == abort_at) break;
      if (n_done > 0) after_done++;
      if (after_done >= 4) break;
    end
  endtask

  task automatic test_reset_idle();
    in_valid = 1'b1;
    {in_r0, in_g0, in_b0, in_r1, in_g1, in_b1} = pair_of(7);
    HRESET = 1'b1;
    start  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 1) HRESET = 1'b0;
      n_checks++;
      if (a_all !== '0) $display("FAIL reset_idle_a[%0d]: got %h required 0", i, a_all);
      else n_pass++;
      n_checks++;
      if (b_all !== '0) $display("FAIL reset_idle_b[%0d]: got %h required 0", i, b_all);
      else n_pass++;
    end
  endtask

  task automatic test_full_frame();
    sel = 1'b0;
    do_reset(2);
    run_frame(0, 0, 1'b0, 1'b1);
    n_checks++;
    if (n_hs != PAIRS) $display("FAIL full_hsync_count: got %0d required %0d", n_hs, PAIRS);
    else n_pass++;
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL full_sb_left: got %0d pending required 0", sb_q.size());
    else n_pass++;
    n_checks++;
    if (n_done != 1 || done_cyc != last_hs_cyc + 1)
      $display("FAIL full_frame_done: got %0d pulses at cycle %0d, required 1 at cycle %0d",
               n_done, done_cyc, last_hs_cyc + 1);
    else n_pass++;
    n_checks++;
    if (mon_row !== 16'd2 || mon_col !== 16'd3)
      $display("FAIL full_final_pos: got row %0d col %0d, required row 2 col 3", mon_row, mon_col);
    else n_pass++;
    n_checks++;
    if (gap_len.size() != 2 || gap_after.size() != 2)
      $display("FAIL full_gap_count: got %0d gaps, required 2", gap_len.size());
    else if (gap_after[0] != 4 || gap_len[0] != 2 || gap_after[1] != 8 || gap_len[1] != 2)
      $display("FAIL full_gap_shape: got after %0d len %0d / after %0d len %0d, required 4/2 8/2",
               gap_after[0], gap_len[0], gap_after[1], gap_len[1]);
    else n_pass++;
    n_checks++;
    if (mon_busy !== 1'b0 || mon_ready !== 1'b0)
      $display("FAIL start_on_done_ignored: got busy %b ready %b, required 0 0", mon_busy, mon_ready);
    else n_pass++;
  endtask

  task automatic test_sparse_valid();
    sel = 1'b1;
    do_reset(2);
    run_frame(1, 0, 1'b1, 1'b0);
    n_checks++;
    if (n_hs != PAIRS) $display("FAIL sparse_hsync_count: got %0d required %0d", n_hs, PAIRS);
    else n_pass++;
    n_checks++;
    if (gap_len.size() != 0 || gap_after.size() != 0)
      $display("FAIL sparse_gaps: got %0d gaps, required 0", gap_after.size());
    else n_pass++;
    n_checks++;
    if (n_done != 1 || sb_q.size() != 0)
      $display("FAIL sparse_done: got %0d pulses %0d pending, required 1 0", n_done, sb_q.size());
    else n_pass++;
    n_checks++;
    if (mon_row !== 16'd2 || mon_col !== 16'd3)
      $display("FAIL sparse_final_pos: got row %0d col %0d, required row 2 col 3", mon_row, mon_col);
    else n_pass++;
  endtask

  task automatic test_mid_frame_reset();
    int events;
    sel = 1'b0;
    do_reset(2);
    run_frame(0, 5, 1'b0, 1'b0);
    n_checks++;
    if (n_hs != 5) $display("FAIL abort_reach: got %0d hsync before abort, required 5", n_hs);
    else n_pass++;
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    n_checks++;
    if (a_all !== '0) $display("FAIL abort_zero: got %h required 0", a_all);
    else n_pass++;
    events = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (a_hsync || a_done || a_busy) events++;
    end
    n_checks++;
    if (events != 0) $display("FAIL abort_quiet: got %0d active cycles, required 0", events);
    else n_pass++;
    run_frame(0, 0, 1'b0, 1'b0);
    n_checks++;
    if (n_hs != PAIRS || n_done != 1 || sb_q.size() != 0)
      $display("FAIL abort_restart: got %0d hsync %0d done %0d pending, required %0d 1 0",
               n_hs, n_done, sb_q.size(), PAIRS);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    int acc_cyc;
    int err_cyc;
    int dones;
    sel = 1'b0;
    do_reset(2);
    k = 0; acc_cyc = -1; err_cyc = -1; dones = 0;
    start = 1'b1;
    for (int t = 0; t < 60; t++) begin
      in_valid = (k < 2);
      {in_r0, in_g0, in_b0, in_r1, in_g1, in_b1} = pair_of(k);
      if (in_valid && a_ready) begin
        k++;
        if (k == 2) acc_cyc = cyc + 1;
      end
      step();
      start = 1'b0;
      if (a_done) dones++;
      if (a_err && err_cyc < 0) err_cyc = cyc;
    end
`ifdef PIXCTRL_TIMEOUT_EN
    n_checks++;
    if (acc_cyc < 0 || err_cyc != acc_cyc + TMO)
      $display("FAIL wd_err_time: got err at cycle %0d, required cycle %0d", err_cyc, acc_cyc + TMO);
    else n_pass++;
    n_checks++;
    if (a_err !== 1'b1 || a_busy !== 1'b0 || dones != 0)
      $display("FAIL wd_state: got err %b busy %b done %0d, required 1 0 0", a_err, a_busy, dones);
    else n_pass++;
    do_reset(1);
    n_checks++;
    if (a_err !== 1'b0) $display("FAIL wd_err_clear: got %b required 0", a_err);
    else n_pass++;
`else
    n_checks++;
    if (acc_cyc < 0 || err_cyc >= 0 || a_err !== 1'b0)
      $display("FAIL nowd_err: got err cycle %0d accept cycle %0d, required no err", err_cyc, acc_cyc);
    else n_pass++;
    n_checks++;
    if (a_busy !== 1'b1 || dones != 0)
      $display("FAIL nowd_busy: got busy %b done %0d, required 1 0", a_busy, dones);
    else n_pass++;
    do_reset(1);
`endif
  endtask

  initial begin
    HRESET   = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    sel      = 1'b0;
    {in_r0, in_g0, in_b0, in_r1, in_g1, in_b1} = '0;
    test_reset_idle();
    test_full_frame();
    test_sparse_valid();
    test_mid_frame_reset();
    test_watchdog();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pix_write_ctrl.md
Name: pix_write_ctrl

Overview:
Frame-write sequencer for the BMP write path. Accepts pixel pairs from an upstream processing stage over a valid/ready handshake and re-times them onto the writer's hsync/DATA_WRITE_* interface, one pair per hsync beat. Tracks row/column position, inserts programmable horizontal blanking between rows, and signals frame completion. Optionally runs a stall watchdog.

Parameters:
WIDTH, 340, image width in pixels; must be even. Pairs per row = WIDTH/2.
HEIGHT, 230, image height in rows.
HBLANK, 4, idle cycles inserted after each row except the last; 0 = no gap.
TIMEOUT, 1024, stall limit in cycles; used only with the optional feature.

Ports:
HCLK  in  1  clock; all logic on the rising edge.
HRESET  in  1  synchronous, active-high reset.
start  in  1  begin one frame; sampled only in IDLE.
in_valid  in  1  upstream pixel pair valid.
in_ready  out  1  ready to accept a pixel pair.
IN_R0, IN_G0, IN_B0, IN_R1, IN_G1, IN_B1  in  8 each  pixel pair; pixel 0 is left of pixel 1.
hsync  out  1  one-cycle write strobe to the writer; registered.
DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0, DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1  out  8 each  registered pixel pair; valid when hsync=1.
row  out  16  current row index, 0..HEIGHT-1.
col  out  16  current pair index within the row, 0..WIDTH/2-1.
busy  out  1  high in every state except IDLE.
frame_done  out  1  one-cycle pulse after the last pair of the frame.
err  out  1  sticky stall error; constant 0 without the optional feature.

Behaviour:
- Reset (HRESET=1 at a clock edge): state=IDLE; every output 0, including all DATA_WRITE_*, row, col and err.
- Reset asserted mid-frame: aborts immediately. No further hsync is issued and frame_done is not pulsed.
- Handshake: a beat is accepted when in_valid && in_ready. in_ready is a registered function of state: 1 only in ACTIVE.
- IDLE:
  - in_ready=0.
  - start=1 -> ACTIVE, with row=0 and col=0.
- ACTIVE, on an accepted beat:
  - Next cycle: DATA_WRITE_* = captured inputs and hsync=1 (latency 1 cycle).
  - With no accepted beat, hsync=0 next cycle and DATA_WRITE_* hold their last values.
  - If col < WIDTH/2-1: col++.
  - Else if row == HEIGHT-1: -> DONE.
  - Else: col=0, row++, then -> BLANK if HBLANK>0, otherwise stay in ACTIVE.
- BLANK:
  - in_ready=0.
  - Down-counter loaded with HBLANK on entry; leave for ACTIVE after exactly HBLANK cycles in BLANK.
- DONE:
  - in_ready=0.
  - frame_done=1 for exactly one cycle, then -> IDLE.
  - row and col hold their final values (HEIGHT-1, WIDTH/2-1) until the next start.
- start outside IDLE is ignored. start in the same cycle frame_done is high is ignored; it must be re-asserted while in IDLE.
- Total hsync pulses per frame = WIDTH*HEIGHT/2. No pair is dropped or duplicated.
- Upstream backpressure is valid-only: in_valid may drop at any time without penalty, except for the optional watchdog.

Optional Feature:
Macro: PIXCTRL_TIMEOUT_EN.
- Defined:
  - A stall counter resets on every accepted beat and on entry to ACTIVE, and increments each ACTIVE cycle with no beat.
  - When it reaches TIMEOUT: err=1 (sticky until HRESET), state -> IDLE, no frame_done pulse.
  - BLANK cycles do not count toward the stall.
- Not defined: no counter is built, err is tied to 0, and ACTIVE waits indefinitely.

Test Plan:
Use WIDTH=8, HEIGHT=3, HBLANK=2 unless noted.
- Reset then idle: hold HRESET 2 cycles, in_valid=1, no start -> in_ready=0, hsync=0, busy=0, all outputs 0.
- Full frame, in_valid held 1: pulse start -> 12 hsync pulses, with a 2-cycle in_ready=0 gap after pairs 4 and 8. frame_done pulses once, 1 cycle after the last hsync. Final row=2, col=3.
- Data ordering: feed pair k as R0=k, G0=k+1, B0=k+2, R1=k+3, G1=k+4, B1=k+5 for k=0..11 -> each hsync cycle presents exactly pair k, in order, 1 cycle after acceptance.
- Sparse valid with HBLANK=0: in_valid toggles every other cycle -> 12 hsync pulses and no blank gaps; start pulsed mid-frame has no effect.
- Mid-frame reset: assert HRESET after pair 5 -> next cycle all outputs 0, state IDLE, no frame_done. A new start then produces a full 12-pair frame.
- Watchdog, built with PIXCTRL_TIMEOUT_EN and TIMEOUT=16: in_valid=0 after pair 2 -> err=1 on the 16th stall cycle, busy=0, no frame_done, err stays 1 until HRESET. Without the macro, the same stimulus leaves busy=1 indefinitely and err=0.
